// File: rtl/object_blitter.sv
// -----------------------------------------------------------------------------
// object_blitter
//   Reads every word of a synchronous object memory (1-cycle read latency) in
//   raster order and turns each word into one VGA plot offset by a screen
//   origin captured when the blit starts. A start/busy/done handshake frames
//   each blit. An erase pass paints the object footprint in BG_COLOR; an
//   optional colour key suppresses plots of transparent words on draw passes.
//
// Ports
//   CLOCK_50   in   clock, all state changes on the rising edge
//   resetn     in   synchronous active-low reset
//   start      in   blit request, only honoured while idle
//   erase      in   captured with start: 1 = erase pass, 0 = draw pass
//   xpos/ypos  in   object origin, captured with start
//   mem_addr   out  object memory address {row, col}
//   mem_data   in   object memory read data, valid one cycle after mem_addr
//   VGA_X/Y    out  pixel coordinate (wraps at the coordinate width)
//   VGA_COLOR  out  pixel colour
//   plot       out  write strobe for VGA_X/VGA_Y/VGA_COLOR
//   busy       out  high while a blit is in progress
//   done       out  one-cycle pulse after the last pixel
// -----------------------------------------------------------------------------
module object_blitter #(
  parameter int          n          = 8,
  parameter int          OBJ_W_LOG2 = 4,
  parameter int          OBJ_H_LOG2 = 4,
  parameter logic [23:0] BG_COLOR   = 24'h0,
  parameter bit          TRANSP_EN  = 1'b0,
  parameter logic [23:0] TRANSP_KEY = 24'hFF00FF
) (
  input  logic                           CLOCK_50,
  input  logic                           resetn,
  input  logic                           start,
  input  logic                           erase,
  input  logic [n-1:0]                   xpos,
  input  logic [n-2:0]                   ypos,
  output logic [OBJ_W_LOG2+OBJ_H_LOG2-1:0] mem_addr,
  input  logic [23:0]                    mem_data,
  output logic [n-1:0]                   VGA_X,
  output logic [n-2:0]                   VGA_Y,
  output logic [23:0]                    VGA_COLOR,
  output logic                           plot,
  output logic                           busy,
  output logic                           done
);

  localparam int            AW   = OBJ_W_LOG2 + OBJ_H_LOG2;
  localparam int            YW   = n - 1;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [AW-1:0]         r_count;
  logic [n-1:0]          r_x_org;
  logic [YW-1:0]         r_y_org;
  logic                  r_erase;
  logic [OBJ_W_LOG2-1:0] r_col;
  logic [OBJ_H_LOG2-1:0] r_row;
  logic                  r_v;
  logic                  r_done;

  logic [n-1:0]          w_x_sum;
  logic [YW-1:0]         w_y_sum;
  logic                  w_keyed;

  // NOTE: reset is sampled on the clock edge (synchronous), and all state
  // updates use non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge CLOCK_50) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  // NOTE: w_next gets its default before the case, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (r_count == LAST) w_next = S_FLUSH;
      S_FLUSH: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      r_count <= '0;
      r_x_org <= '0;
      r_y_org <= '0;
      r_erase <= 1'b0;
      r_col   <= '0;
      r_row   <= '0;
      r_v     <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= (r_state == S_FLUSH);
      if (r_state == S_IDLE && start) begin
        r_x_org <= xpos;
        r_y_org <= ypos;
        r_erase <= erase;
        r_count <= '0;
      end else if (r_state == S_RUN) begin
        // Rolls over to zero on the last address, ready for the next blit.
        r_count <= r_count + AW'(1);
      end
      // One stage behind the address so the coordinates line up with mem_data.
      r_col <= r_count[OBJ_W_LOG2-1:0];
      r_row <= r_count[AW-1:OBJ_W_LOG2];
      r_v   <= (r_state == S_RUN);
    end
  end

  assign mem_addr = r_count;

  assign w_x_sum = r_x_org + n'(r_col);
  assign w_y_sum = r_y_org + YW'(r_row);
  assign w_keyed = TRANSP_EN && (mem_data == TRANSP_KEY);

  // Outputs are held at zero whenever no pixel is in flight, so the raw
  // memory word never leaks onto VGA_COLOR while idle or after reset.
  assign VGA_X     = r_v ? w_x_sum : '0;
  assign VGA_Y     = r_v ? w_y_sum : '0;
  assign VGA_COLOR = r_v ? (r_erase ? BG_COLOR : mem_data) : 24'h0;
  assign plot      = r_v && (r_erase || !w_keyed);
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_object_blitter.sv
// -----------------------------------------------------------------------------
// tb_object_blitter
//   Two instances share all inputs: dut 0 uses the default parameters, dut 1
//   enables colour-key transparency and a non-zero background colour. Each
//   instance has its own 1-cycle-latency ROM model reading a shared content
//   array. Expected plots come from the raster rules (origin + col/row, wrap,
//   key suppression, erase colour) evaluated per pixel index.
// -----------------------------------------------------------------------------
module tb_object_blitter;

  localparam int          N    = 256;
  localparam int          NCAP = 261;
  localparam logic [23:0] KEY  = 24'hFF00FF;
  localparam logic [23:0] BG1  = 24'h123456;

  typedef struct packed {
    logic [8:0]  m;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [23:0] c;
  } plot_t;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        erase;
  logic [7:0]  xpos;
  logic [6:0]  ypos;

  logic [7:0]  ma [2];
  logic [23:0] md [2];
  logic [7:0]  vx [2];
  logic [6:0]  vy [2];
  logic [23:0] vc [2];
  logic        pl [2];
  logic        bz [2];
  logic        dn [2];

  logic [23:0] rom [N];

  int checks   = 0;
  int failures = 0;

  plot_t            obs    [2][300];
  int               obs_n  [2];
  logic [NCAP-1:0]  busy_v [2];
  logic [NCAP-1:0]  done_v [2];
  logic [73:0]      snap   [2];

  plot_t            exp_pl [2][N];
  int               exp_n  [2];
  logic [NCAP-1:0]  exp_busy;
  logic [NCAP-1:0]  exp_done;

  object_blitter u_dut0 (
    .CLOCK_50 (clk),    .resetn (resetn), .start (start), .erase (erase),
    .xpos     (xpos),   .ypos   (ypos),   .mem_addr (ma[0]), .mem_data (md[0]),
    .VGA_X    (vx[0]),  .VGA_Y  (vy[0]),  .VGA_COLOR (vc[0]),
    .plot     (pl[0]),  .busy   (bz[0]),  .done (dn[0])
  );

  object_blitter #(.BG_COLOR(BG1), .TRANSP_EN(1'b1), .TRANSP_KEY(KEY)) u_dut1 (
    .CLOCK_50 (clk),    .resetn (resetn), .start (start), .erase (erase),
    .xpos     (xpos),   .ypos   (ypos),   .mem_addr (ma[1]), .mem_data (md[1]),
    .VGA_X    (vx[1]),  .VGA_Y  (vy[1]),  .VGA_COLOR (vc[1]),
    .plot     (pl[1]),  .busy   (bz[1]),  .done (dn[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    md[0] <= rom[ma[0]];
    md[1] <= rom[ma[1]];
  end

  // ---------------------------------------------------------------- stimulus
  task automatic fill_random();
    for (int i = 0; i < N; i++) rom[i] = 24'($urandom);
  endtask

  task automatic fill_keyed();
    for (int i = 0; i < N; i++) rom[i] = 24'(i);
    rom[8'h11] = KEY;
    for (int k = 0; k < 3; k++) rom[$urandom_range(32, 255)] = KEY;
  endtask

  task automatic issue_start(input logic [7:0] x, input logic [6:0] y, input logic e);
    @(negedge clk);
    xpos  = x;
    ypos  = y;
    erase = e;
    start = 1'b1;
    @(negedge clk);
  endtask

  // Samples cycles m = 0..last_m after the accepting edge k (m = cycle after
  // edge k+m). pulse_m: raise start for one cycle and change the origin/erase
  // inputs; hold_m: keep start high from there on; rst_m: drive resetn low.
  task automatic capture(input int last_m, input int pulse_m, input int hold_m,
                         input int rst_m, input logic [7:0] nx,
                         input logic [6:0] ny, input logic ne);
    for (int d = 0; d < 2; d++) begin
      obs_n[d]  = 0;
      busy_v[d] = '0;
      done_v[d] = '0;
      snap[d]   = '1;
    end
    for (int m = 0; m <= last_m; m++) begin
      for (int d = 0; d < 2; d++) begin
        if (pl[d]) begin
          if (obs_n[d] < 300) obs[d][obs_n[d]] = {9'(m), vx[d], vy[d], vc[d]};
          obs_n[d]++;
        end
        busy_v[d][m] = bz[d];
        done_v[d][m] = dn[d];
        if (m == rst_m + 1)
          snap[d] = {pl[d], bz[d], dn[d], vx[d], vy[d], vc[d], ma[d], 24'h0};
      end
      if (m == pulse_m) begin
        xpos  = nx;
        ypos  = ny;
        erase = ne;
      end
      start  = (m == pulse_m) || (hold_m >= 0 && m >= hold_m);
      resetn = (m != rst_m);
      @(negedge clk);
    end
    start  = 1'b0;
    resetn = 1'b1;
  endtask

  // ----------------------------------------------------------- reference model
  task automatic model_blit(input logic [7:0] x, input logic [6:0] y, input logic e,
                            input int last_m, input int rst_m);
    exp_busy = '0;
    exp_done = '0;
    for (int d = 0; d < 2; d++) exp_n[d] = 0;
    for (int m = 0; m <= last_m; m++) begin
      if (m <= N && (rst_m < 0 || m <= rst_m)) exp_busy[m] = 1'b1;
      if (m == N + 1 && rst_m < 0) exp_done[m] = 1'b1;
    end
    for (int i = 0; i < N; i++) begin
      int m;
      m = i + 1;
      if (m <= last_m && (rst_m < 0 || m <= rst_m)) begin
        for (int d = 0; d < 2; d++) begin
          if (e || d == 0 || rom[i] != KEY) begin
            exp_pl[d][exp_n[d]] = {9'(m), 8'(x + i % 16), 7'(y + i / 16),
                                   e ? (d == 0 ? 24'h0 : BG1) : rom[i]};
            exp_n[d]++;
          end
        end
      end
    end
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b1;
    erase  = 1'b1;
    xpos   = 8'($urandom);
    ypos   = 7'($urandom);
    fill_random();
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({pl[d], bz[d], dn[d], vx[d], vy[d], vc[d], ma[d]} !== '0) begin
        failures++;
        $display("FAIL reset dut%0d got plot=%b busy=%b done=%b x=%0d y=%0d c=%06h addr=%0d want all 0",
                 d, pl[d], bz[d], dn[d], vx[d], vy[d], vc[d], ma[d]);
      end
    end
    resetn = 1'b1;
    start  = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({pl[d], bz[d], dn[d]} !== 3'b000) begin
        failures++;
        $display("FAIL reset_release dut%0d got plot=%b busy=%b done=%b want 0 0 0",
                 d, pl[d], bz[d], dn[d]);
      end
    end
  endtask

  task automatic test_draw();
    logic [7:0] x;
    logic [6:0] y;
    for (int it = 0; it < 3; it++) begin
      if (it == 0) begin
        for (int i = 0; i < N; i++) rom[i] = 24'(i);
        x = 8'd10;
        y = 7'd20;
      end else begin
        fill_random();
        x = 8'($urandom);
        y = 7'($urandom);
      end
      issue_start(x, y, 1'b0);
      capture(258, -1, -1, -1, 8'h0, 7'h0, 1'b0);
      model_blit(x, y, 1'b0, 258, -1);
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_n[d] !== exp_n[d]) begin
          failures++;
          $display("FAIL draw%0d dut%0d plot_count got=%0d want=%0d", it, d, obs_n[d], exp_n[d]);
        end
        for (int j = 0; j < obs_n[d] && j < exp_n[d]; j++) begin
          checks++;
          if (obs[d][j] !== exp_pl[d][j]) begin
            failures++;
            if (failures < 40)
              $display("FAIL draw%0d dut%0d plot%0d got m/x/y/c=%0d/%0d/%0d/%06h want %0d/%0d/%0d/%06h",
                       it, d, j, obs[d][j].m, obs[d][j].x, obs[d][j].y, obs[d][j].c,
                       exp_pl[d][j].m, exp_pl[d][j].x, exp_pl[d][j].y, exp_pl[d][j].c);
          end
        end
        checks++;
        if (busy_v[d] !== exp_busy) begin
          failures++;
          $display("FAIL draw%0d dut%0d busy got=%h want=%h", it, d, busy_v[d], exp_busy);
        end
        checks++;
        if (done_v[d] !== exp_done) begin
          failures++;
          $display("FAIL draw%0d dut%0d done got=%h want=%h", it, d, done_v[d], exp_done);
        end
      end
    end
  endtask

  // Shared body for transparency, erase and wrap scenarios.
  task automatic run_single(input string name, input logic [7:0] x, input logic [6:0] y,
                            input logic e);
    issue_start(x, y, e);
    capture(258, -1, -1, -1, 8'h0, 7'h0, 1'b0);
    model_blit(x, y, e, 258, -1);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (obs_n[d] !== exp_n[d]) begin
        failures++;
        $display("FAIL %s dut%0d plot_count got=%0d want=%0d", name, d, obs_n[d], exp_n[d]);
      end
      for (int j = 0; j < obs_n[d] && j < exp_n[d]; j++) begin
        checks++;
        if (obs[d][j] !== exp_pl[d][j]) begin
          failures++;
          if (failures < 40)
            $display("FAIL %s dut%0d plot%0d got m/x/y/c=%0d/%0d/%0d/%06h want %0d/%0d/%0d/%06h",
                     name, d, j, obs[d][j].m, obs[d][j].x, obs[d][j].y, obs[d][j].c,
                     exp_pl[d][j].m, exp_pl[d][j].x, exp_pl[d][j].y, exp_pl[d][j].c);
        end
      end
      checks++;
      if (busy_v[d] !== exp_busy) begin
        failures++;
        $display("FAIL %s dut%0d busy got=%h want=%h", name, d, busy_v[d], exp_busy);
      end
      checks++;
      if (done_v[d] !== exp_done) begin
        failures++;
        $display("FAIL %s dut%0d done got=%h want=%h", name, d, done_v[d], exp_done);
      end
    end
  endtask

  task automatic test_transparency();
    fill_keyed();
    run_single("transparency", 8'd10, 7'd20, 1'b0);
  endtask

  task automatic test_erase();
    fill_keyed();
    run_single("erase", 8'd10, 7'd20, 1'b1);
  endtask

  task automatic test_wrap();
    fill_random();
    rom[8'h05] = KEY;
    run_single("wrap", 8'd250, 7'd120, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic       e1;
    fill_random();
    rom[8'h40] = KEY;
    x0 = 8'($urandom);
    y0 = 7'($urandom);
    x1 = 8'($urandom);
    y1 = 7'($urandom);
    e1 = 1'($urandom);
    issue_start(x0, y0, 1'b0);
    // Start pulse and input change at pixel 50 must be ignored; start held
    // from m=200 is taken in the done cycle and launches the second blit.
    capture(257, 50, 200, -1, x1, y1, e1);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) model_blit(x0, y0, 1'b0, 257, -1);
      else begin
        capture(258, -1, -1, -1, 8'h0, 7'h0, 1'b0);
        model_blit(x1, y1, e1, 258, -1);
      end
      for (int d = 0; d < 2; d++) begin
        checks++;
        if (obs_n[d] !== exp_n[d]) begin
          failures++;
          $display("FAIL b2b%0d dut%0d plot_count got=%0d want=%0d", pass, d, obs_n[d], exp_n[d]);
        end
        for (int j = 0; j < obs_n[d] && j < exp_n[d]; j++) begin
          checks++;
          if (obs[d][j] !== exp_pl[d][j]) begin
            failures++;
            if (failures < 40)
              $display("FAIL b2b%0d dut%0d plot%0d got m/x/y/c=%0d/%0d/%0d/%06h want %0d/%0d/%0d/%06h",
                       pass, d, j, obs[d][j].m, obs[d][j].x, obs[d][j].y, obs[d][j].c,
                       exp_pl[d][j].m, exp_pl[d][j].x, exp_pl[d][j].y, exp_pl[d][j].c);
          end
        end
        checks++;
        if (busy_v[d] !== exp_busy) begin
          failures++;
          $display("FAIL b2b%0d dut%0d busy got=%h want=%h", pass, d, busy_v[d], exp_busy);
        end
        checks++;
        if (done_v[d] !== exp_done) begin
          failures++;
          $display("FAIL b2b%0d dut%0d done got=%h want=%h", pass, d, done_v[d], exp_done);
        end
      end
    end
  endtask

  task automatic test_reset_mid_blit();
    logic [7:0] x;
    logic [6:0] y;
    fill_random();
    x = 8'($urandom);
    y = 7'($urandom);
    issue_start(x, y, 1'b0);
    // Pixel 100 is presented at m=101; reset is taken on the following edge.
    capture(130, -1, -1, 101, 8'h0, 7'h0, 1'b0);
    model_blit(x, y, 1'b0, 130, 101);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (snap[d] !== 74'h0) begin
        failures++;
        $display("FAIL reset_mid dut%0d outputs after reset got=%h want 0", d, snap[d]);
      end
      checks++;
      if (obs_n[d] !== exp_n[d]) begin
        failures++;
        $display("FAIL reset_mid dut%0d plot_count got=%0d want=%0d", d, obs_n[d], exp_n[d]);
      end
      for (int j = 0; j < obs_n[d] && j < exp_n[d]; j++) begin
        checks++;
        if (obs[d][j] !== exp_pl[d][j]) begin
          failures++;
          if (failures < 40)
            $display("FAIL reset_mid dut%0d plot%0d got=%h want=%h", d, j, obs[d][j], exp_pl[d][j]);
        end
      end
      checks++;
      if (busy_v[d] !== exp_busy) begin
        failures++;
        $display("FAIL reset_mid dut%0d busy got=%h want=%h", d, busy_v[d], exp_busy);
      end
      checks++;
      if (done_v[d] !== exp_done) begin
        failures++;
        $display("FAIL reset_mid dut%0d done got=%h want=%h", d, done_v[d], exp_done);
      end
    end
    // A fresh blit after the abandoned one must start again from address 0.
    run_single("restart", 8'($urandom), 7'($urandom), 1'b0);
  endtask

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    erase  = 1'b0;
    xpos   = '0;
    ypos   = '0;
    test_reset();
    test_draw();
    test_transparency();
    test_erase();
    test_wrap();
    test_back_to_back();
    test_reset_mid_blit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
